// File: rtl/pcm_to_dsd_pkg.sv
// pcm_to_dsd_pkg: shared parameter math, state width and saturating add for pcm_to_dsd.
package pcm_to_dsd_pkg;

   localparam int MAX_W = 64;

   function automatic int calc_div(input int clk_hz, input int dsd_hz);
      return clk_hz / dsd_hz;
   endfunction

   function automatic int state_width(input int sample_width);
      return sample_width + 4;
   endfunction

   // Two spare bits keep the 64-bit pre-saturation sum from overflowing.
   function automatic bit params_ok(input int clk_hz, input int dsd_hz, input int osr, input int sample_width);
      return dsd_hz > 0 && calc_div(clk_hz, dsd_hz) >= 2 && osr >= 2 && sample_width >= 2
             && state_width(sample_width) <= MAX_W - 2;
   endfunction

   // Adds two sign-extended operands and clamps to the range of a w-bit signed value.
   function automatic logic signed [MAX_W-1:0] sat_add(input logic signed [MAX_W-1:0] a,
                                                       input logic signed [MAX_W-1:0] b,
                                                       input int w);
      logic signed [MAX_W-1:0] s, hi, lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return s > hi ? hi : (s < lo ? lo : s);
   endfunction

endpackage

// File: rtl/dsm2_core.sv
// dsm2_core: second-order delta-sigma modulator, one output bit per enable.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   en      evaluate one modulator step
//   x       signed input sample
//   bit_out registered 1-bit output, 1 = positive full scale
module dsm2_core
   import pcm_to_dsd_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic signed [SAMPLE_WIDTH-1:0] x,
   output logic                           bit_out
);

   localparam int W = state_width(SAMPLE_WIDTH);
   localparam logic signed [MAX_W-1:0] FS = 64'sd1 <<< (SAMPLE_WIDTH - 1);

   logic signed [W-1:0]     i1, i2, i1_n, i2_n;
   logic signed [MAX_W-1:0] xs, fb;

   // Input is halved to keep the second-order loop inside its stable range.
   always_comb begin
      xs   = 64'(x) >>> 1;
      fb   = bit_out ? FS : -FS;
      i1_n = W'(sat_add(64'(i1), xs - fb, W));
      i2_n = W'(sat_add(64'(i2), 64'(i1_n) - fb, W));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i1      <= '0;
         i2      <= '0;
         bit_out <= 1'b0;
      end else if (en) begin
         i1      <= i1_n;
         i2      <= i2_n;
         bit_out <= ~i2_n[W-1];
      end
   end

endmodule

// File: rtl/pcm_to_dsd.sv
// pcm_to_dsd: PCM sample stream to 1-bit DSD bitstream with local bit-rate enable.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pcm_sample signed PCM input, captured whenever pcm_valid is high
//   pcm_valid  sample strobe
//   pcm_ready  one-cycle request for the next sample
//   dsd_bit    modulator output bit
//   dsd_ce     one-cycle strobe marking a new dsd_bit
module pcm_to_dsd
   import pcm_to_dsd_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 24,
   parameter int CLK_FREQ_HZ  = 100_000_000,
   parameter int DSD_FREQ_HZ  = 3_125_000,
   parameter int OSR          = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic signed [SAMPLE_WIDTH-1:0] pcm_sample,
   input  logic                           pcm_valid,
   output logic                           pcm_ready,
   output logic                           dsd_bit,
   output logic                           dsd_ce
);

   localparam int DIV = calc_div(CLK_FREQ_HZ, DSD_FREQ_HZ);
   localparam int DW  = $clog2(DIV);
   localparam int BW  = $clog2(OSR);

   if (!params_ok(CLK_FREQ_HZ, DSD_FREQ_HZ, OSR, SAMPLE_WIDTH)) begin : g_param_err
      $error("pcm_to_dsd: DIV and OSR must be >= 2");
   end

   logic [DW-1:0]                  div_cnt;
   logic [BW-1:0]                  bit_cnt;
   logic                           primed, tick, last_bit;
   logic signed [SAMPLE_WIDTH-1:0] x_hold;

   always_comb begin
      tick     = div_cnt == DW'(DIV - 1);
      last_bit = bit_cnt == BW'(OSR - 1);
   end

   // primed produces the single request pulse on the first clock after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         primed    <= 1'b0;
         pcm_ready <= 1'b0;
         dsd_ce    <= 1'b0;
         x_hold    <= '0;
      end else begin
         div_cnt   <= tick ? '0 : div_cnt + 1'b1;
         if (tick) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
         primed    <= 1'b1;
         pcm_ready <= (tick && last_bit) || !primed;
         dsd_ce    <= tick;
         if (pcm_valid) x_hold <= pcm_sample;
      end
   end

   dsm2_core #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (tick),
      .x      (x_hold),
      .bit_out(dsd_bit)
   );

endmodule

// File: tb/tb_pcm_to_dsd.sv
// tb_pcm_to_dsd: randomized scoreboard bench for pcm_to_dsd with a frame-level reference model.
module tb_pcm_to_dsd;

   localparam int SW = 24, DIV = 32, OSR = 64, FRAME = DIV * OSR, NF = 16, F1 = 12;
   localparam longint FS = 64'sd1 <<< (SW - 1);
   localparam longint HI = (64'sd1 <<< (SW + 3)) - 1;
   localparam longint LO = -(64'sd1 <<< (SW + 3));

   logic clk = 1'b0, rst_n = 1'b0, pcm_valid = 1'b0;
   logic signed [SW-1:0] pcm_sample = '0;
   logic pcm_ready, dsd_bit, dsd_ce;

   int total = 0, bad = 0, cyc = 0, phase = 1, bit_idx = 0, dc_ones = 0;
   logic last_bit = 1'b0;
   bit run1[$], exp_q[$];
   longint samp[NF], samp2[NF];
   int mode[NF];
   longint m_i1, m_i2, m_hold;
   bit m_prev;

   always #5 clk = ~clk;

   pcm_to_dsd dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pcm_sample(pcm_sample),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .dsd_bit   (dsd_bit),
      .dsd_ce    (dsd_ce)
   );

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint clamp(input longint v);
      return v > HI ? HI : (v < LO ? LO : v);
   endfunction

   task automatic model_reset();
      m_i1 = 0; m_i2 = 0; m_hold = 0; m_prev = 0;
      exp_q.delete();
   endtask

   // One frame = OSR modulator steps on the currently held sample.
   task automatic model_frame();
      longint x, fb;
      repeat (OSR) begin
         x      = m_hold >>> 1;
         fb     = m_prev ? FS : -FS;
         m_i1   = clamp(m_i1 + x - fb);
         m_i2   = clamp(m_i2 + m_i1 - fb);
         m_prev = m_i2 >= 0;
         exp_q.push_back(m_prev);
      end
   endtask

   task automatic do_frame(input int f);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pcm_ready && n < FRAME + 100);
      check("ready_seen", pcm_ready, 1);
      if (mode[f] != 1) begin
         pcm_valid = 1'b1; pcm_sample = SW'(samp[f]); m_hold = samp[f];
         @(negedge clk);
         pcm_valid = 1'b0;
      end
      if (mode[f] == 2) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         pcm_valid = 1'b1; pcm_sample = SW'(samp2[f]); m_hold = samp2[f];
         @(negedge clk);
         pcm_valid = 1'b0;
      end
      model_frame();
   endtask

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) bit_idx <= 0;
      else begin
         check("pcm_ready", pcm_ready, cyc == 1 || (cyc > 0 && cyc % FRAME == 0));
         check("dsd_ce", dsd_ce, cyc > 0 && cyc % DIV == 0);
         if (!dsd_ce) check("bit_hold", dsd_bit, last_bit);
         else begin
            if (exp_q.size() == 0) check("bit_expected", exp_q.size(), 1);
            else check("dsd_bit", dsd_bit, exp_q.pop_front());
            if (phase == 1) run1.push_back(dsd_bit);
            else if (bit_idx < run1.size()) check("replay", dsd_bit, run1[bit_idx]);
            if (phase == 2 && bit_idx >= 13 * OSR && bit_idx < 16 * OSR) dc_ones <= dc_ones + int'(dsd_bit);
            bit_idx <= bit_idx + 1;
         end
      end
      last_bit <= dsd_bit;
   end

   initial begin
      int n, ces;
      logic signed [SW-1:0] r;
      for (int f = 0; f < NF; f++) begin
         r = SW'($urandom); samp[f] = r;
         r = SW'($urandom); samp2[f] = r;
         n = $urandom_range(0, 4);
         mode[f] = (f < 3 || f >= 12) ? 0 : (n == 0 ? 1 : (n == 1 ? 2 : 0));
      end
      samp[1] = -FS;
      samp[2] = FS - 1;
      for (int f = 13; f < 16; f++) samp[f] = 4194304;

      model_reset();
      repeat (20) @(negedge clk);
      check("rst_dsd_bit", dsd_bit, 0);
      check("rst_dsd_ce", dsd_ce, 0);
      check("rst_pcm_ready", pcm_ready, 0);
      rst_n = 1'b1;
      for (int f = 0; f < F1; f++) do_frame(f);

      n = 0; ces = 0;
      do begin
         @(negedge clk);
         n++;
         if (dsd_ce) ces++;
      end while (!(ces >= 30 && dsd_ce && dsd_bit) && n < 2 * FRAME);
      check("bit30_wait", dsd_ce & dsd_bit, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_dsd_bit", dsd_bit, 0);
      check("async_dsd_ce", dsd_ce, 0);
      check("async_pcm_ready", pcm_ready, 0);
      phase = 2;
      model_reset();
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      for (int f = 0; f < NF; f++) do_frame(f);

      n = 0;
      while (exp_q.size() != 0 && n < FRAME + 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      total++;
      if (dc_ones < 114 || dc_ones > 126) begin
         bad++;
         $display("FAIL dc_density: ones %0d want 120+-6 of 192", dc_ones);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
